// File: rtl/alu_pkg.sv
// Shared encodings for the alu_mdu_seq execute unit.
// The operation code is {m_ext, imm7[5], funct3}.
package alu_pkg;

    typedef logic [4:0] op_t;

    localparam op_t OP_ADD    = 5'b00000;
    localparam op_t OP_SLL    = 5'b00001;
    localparam op_t OP_SLT    = 5'b00010;
    localparam op_t OP_SLTU   = 5'b00011;
    localparam op_t OP_XOR    = 5'b00100;
    localparam op_t OP_SRL    = 5'b00101;
    localparam op_t OP_OR     = 5'b00110;
    localparam op_t OP_AND    = 5'b00111;
    localparam op_t OP_SUB    = 5'b01000;
    localparam op_t OP_SRA    = 5'b01101;
    localparam op_t OP_MUL    = 5'b10000;
    localparam op_t OP_MULH   = 5'b10001;
    localparam op_t OP_MULHSU = 5'b10010;
    localparam op_t OP_MULHU  = 5'b10011;
    localparam op_t OP_DIV    = 5'b10100;
    localparam op_t OP_DIVU   = 5'b10101;
    localparam op_t OP_REM    = 5'b10110;
    localparam op_t OP_REMU   = 5'b10111;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational base-integer ALU.
// Any encoding outside the base set yields zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  op_t             op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] sh;
    assign sh = b[SHW-1:0];

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_SLL:  y = a << sh;
            OP_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  y = a ^ b;
            OP_SRL:  y = a >> sh;
            OP_SRA:  y = $unsigned($signed(a) >>> sh);
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_mdu_seq.sv
// EX-stage execute unit: single-cycle base ALU plus an iterative radix-2
// multiply/divide datapath, behind valid/ready handshakes on both sides.
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [4:0]      operation,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Handshake: an op transfers on in_valid && in_ready, a result on
    // out_valid && out_ready; both sides hold their payload until the transfer.
    state_t          state, state_next;
    logic [SHW-1:0]  cnt;
    logic [XLEN-1:0] res, hi, lo, dvs;
    logic [2:0]      fn;
    logic            neg;

    logic            accept, m_ext, imm5, is_div, div0, ovf, m_iter;
    logic [2:0]      f3;
    logic            sgn1_en, sgn2_en, s1, s2;
    logic [XLEN-1:0] mag1, mag2, core_y, special, fix_val;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC) || (state == FIX);
    assign result    = (state == DONE) ? res : '0;

    assign accept = in_valid && in_ready;
    assign m_ext  = operation[4];
    assign imm5   = operation[3];
    assign f3     = operation[2:0];
    assign is_div = f3[2];
    assign div0   = is_div && (operand2 == '0);
    assign ovf    = is_div && !f3[0] && (operand1 == MOST_NEG) && (operand2 == '1);
    assign m_iter = m_ext && !imm5 && !div0 && !ovf;

    // MULHSU keeps operand1 signed but treats operand2 as unsigned.
    assign sgn1_en = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                     (f3 == 3'b100) || (f3 == 3'b110);
    assign sgn2_en = (f3 == 3'b000) || (f3 == 3'b001) ||
                     (f3 == 3'b100) || (f3 == 3'b110);
    assign s1   = sgn1_en && operand1[XLEN-1];
    assign s2   = sgn2_en && operand2[XLEN-1];
    assign mag1 = s1 ? -operand1 : operand1;
    assign mag2 = s2 ? -operand2 : operand2;

    alu_core #(.XLEN(XLEN)) u_core (
        .op (operation),
        .a  (operand1),
        .b  (operand2),
        .y  (core_y)
    );

    always_comb begin
        special = '0;
        if (m_ext && !imm5) begin
            if (div0)
                special = f3[1] ? operand1 : '1;
            else if (ovf)
                special = f3[1] ? '0 : operand1;
        end
    end

    logic [2*XLEN-1:0] prod, prod_n;
    assign prod   = {hi, lo};
    assign prod_n = neg ? -prod : prod;

    always_comb begin
        fix_val = '0;
        case (fn)
            3'b000:                 fix_val = prod_n[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_n[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = neg ? -lo : lo;
            default:                fix_val = neg ? -hi : hi;
        endcase
    end

    // One radix-2 step: multiply adds the multiplicand into the upper half and
    // shifts right; divide shifts the next dividend bit in and trial-subtracts.
    logic [XLEN:0]   mul_sum, div_shift;
    logic [XLEN+1:0] div_trial;
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    assign div_shift = {hi, lo[XLEN-1]};
    assign div_trial = {1'b0, div_shift} - {2'b00, dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = m_iter ? CALC : DONE;
            CALC: if (cnt == SHW'(XLEN-1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            res <= '0;
            hi  <= '0;
            lo  <= '0;
            dvs <= '0;
            fn  <= '0;
            neg <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt <= '0;
                    fn  <= f3;
                    neg <= (f3 == 3'b110) ? s1 : (s1 ^ s2);
                    hi  <= '0;
                    lo  <= is_div ? mag1 : mag2;
                    dvs <= is_div ? mag2 : mag1;
                    if (!m_iter)
                        res <= m_ext ? special : core_y;
                end
                CALC: begin
                    cnt <= cnt + SHW'(1);
                    if (fn[2]) begin
                        if (!div_trial[XLEN+1]) begin
                            hi <= div_trial[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b1};
                        end else begin
                            hi <= div_shift[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi <= mul_sum[XLEN:1];
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                end
                FIX: res <= fix_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq at XLEN=32 and XLEN=64 with hand-computed
// expected results, latencies and busy durations.
module tb_alu_mdu_seq;

    logic        clk;
    logic        rst_n;

    logic        iv32, ir32, ov32, or32, busy32;
    logic [31:0] a32, b32, res32;
    logic [4:0]  op32;

    logic        iv64, ir64, ov64, or64, busy64;
    logic [63:0] a64, b64, res64;
    logic [4:0]  op64;

    int n_pass  = 0;
    int n_total = 0;

    alu_mdu_seq #(.XLEN(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv32),
        .in_ready  (ir32),
        .operand1  (a32),
        .operand2  (b32),
        .operation (op32),
        .out_valid (ov32),
        .out_ready (or32),
        .result    (res32),
        .busy      (busy32)
    );

    alu_mdu_seq #(.XLEN(64)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv64),
        .in_ready  (ir64),
        .operand1  (a64),
        .operand2  (b64),
        .operation (op64),
        .out_valid (ov64),
        .out_ready (or64),
        .result    (res64),
        .busy      (busy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic sel_ov(input bit wide);
        return wide ? ov64 : ov32;
    endfunction

    function automatic logic sel_ir(input bit wide);
        return wide ? ir64 : ir32;
    endfunction

    function automatic logic sel_busy(input bit wide);
        return wide ? busy64 : busy32;
    endfunction

    function automatic logic [63:0] sel_res(input bit wide);
        return wide ? res64 : {32'h0, res32};
    endfunction

    task automatic drive(input bit wide, input logic v, input logic [4:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (wide) begin
            iv64 = v; op64 = op; a64 = a; b64 = b;
        end else begin
            iv32 = v; op32 = op; a32 = a[31:0]; b32 = b[31:0];
        end
    endtask

    task automatic set_out_ready(input bit wide, input logic r);
        if (wide) or64 = r;
        else      or32 = r;
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge with it idle again.
    task automatic run_op(input bit wide, input logic [4:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                          input string tag, input int hold, input bit poke);
        int lat;
        int bcnt;
        check({tag, "_in_ready"}, 64'(sel_ir(wide)), 64'd1);
        drive(wide, 1'b1, op, a, b);
        @(posedge clk);
        lat  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (poke && lat >= 3 && lat <= 8)
                drive(wide, 1'b1, 5'b00000, ~a, ~b);
            else
                drive(wide, 1'b0, 5'b00111, ~a, 64'h5a5a);
            if (sel_busy(wide)) bcnt++;
        end while (!sel_ov(wide) && lat < 200);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat - 1));
        check({tag, "_result"}, sel_res(wide), exp);
        for (int i = 0; i < hold; i++) begin
            drive(wide, 1'b1, 5'b00000, 64'h1, 64'h1);
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(sel_ov(wide)), 64'd1);
            check({tag, "_hold_result"}, sel_res(wide), exp);
            check({tag, "_hold_in_ready"}, 64'(sel_ir(wide)), 64'd0);
        end
        drive(wide, 1'b0, 5'b00000, 64'h0, 64'h0);
        set_out_ready(wide, 1'b1);
        @(negedge clk);
        set_out_ready(wide, 1'b0);
        check({tag, "_consumed_valid"}, 64'(sel_ov(wide)), 64'd0);
        check({tag, "_consumed_result"}, sel_res(wide), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        iv32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; or32 = 1'b0;
        iv64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; or64 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(ov32), 64'd0);
        check("reset_busy", 64'(busy32), 64'd0);
        check("reset_result", {32'h0, res32}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 64'(ir32), 64'd1);

        run_op(0, 5'b00000, 64'h7fffffff, 64'h1,        64'h80000000, 1,  "add_wrap",  0, 0);
        run_op(0, 5'b01101, 64'h80000000, 64'd31,       64'hffffffff, 1,  "sra_31",    0, 0);
        run_op(0, 5'b01000, 64'd5,        64'd7,        64'hfffffffe, 1,  "sub_neg",   0, 0);
        run_op(0, 5'b00010, 64'hffffffff, 64'd1,        64'd1,        1,  "slt",       0, 0);
        run_op(0, 5'b00011, 64'hffffffff, 64'd1,        64'd0,        1,  "sltu",      0, 0);
        run_op(0, 5'b00001, 64'h00000003, 64'h00000024, 64'h00000030, 1,  "sll_mask",  0, 0);
        run_op(0, 5'b01010, 64'h12345678, 64'h1,        64'd0,        1,  "base_undef",0, 0);
        run_op(0, 5'b10001, 64'hfffffffd, 64'd5,        64'hffffffff, 34, "mulh",      0, 0);
        run_op(0, 5'b10000, 64'hfffffffd, 64'd5,        64'hfffffff1, 34, "mul_poke",  0, 1);
        run_op(0, 5'b10011, 64'hffffffff, 64'hffffffff, 64'hfffffffe, 34, "mulhu_hold",5, 0);
        run_op(0, 5'b10010, 64'hffffffff, 64'hffffffff, 64'hffffffff, 34, "mulhsu",    0, 0);
        run_op(0, 5'b10100, 64'hfffffff9, 64'd2,        64'hfffffffd, 34, "div",       0, 0);
        run_op(0, 5'b10110, 64'hfffffff9, 64'd2,        64'hffffffff, 34, "rem",       0, 0);
        run_op(0, 5'b10101, 64'd100,      64'd7,        64'd14,       34, "divu",      0, 0);
        run_op(0, 5'b10111, 64'd100,      64'd7,        64'd2,        34, "remu",      0, 0);
        run_op(0, 5'b10101, 64'd7,        64'd0,        64'hffffffff, 1,  "divu_by0",  0, 0);
        run_op(0, 5'b10111, 64'd7,        64'd0,        64'd7,        1,  "remu_by0",  0, 0);
        run_op(0, 5'b10100, 64'h80000000, 64'hffffffff, 64'h80000000, 1,  "div_ovf",   0, 0);
        run_op(0, 5'b10110, 64'h80000000, 64'hffffffff, 64'd0,        1,  "rem_ovf",   0, 0);

        // Abort a multiply partway through CALC with an asynchronous reset.
        drive(0, 1'b1, 5'b10000, 64'h1234, 64'h5678);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 5'b00000, 64'h0, 64'h0);
        repeat (10) @(posedge clk);
        #2;
        check("abort_busy_before", 64'(busy32), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(ov32), 64'd0);
        check("abort_busy", 64'(busy32), 64'd0);
        check("abort_result", {32'h0, res32}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 5'b00000, 64'd2, 64'd3, 64'd5, 1, "add_after_abort", 0, 0);

        run_op(1, 5'b10011, 64'h8000000000000000, 64'd4, 64'd2, 66, "mulhu64", 0, 0);
        run_op(1, 5'b11000, 64'hdeadbeefcafef00d, 64'd9, 64'd0, 1,  "undef64", 0, 0);
        run_op(1, 5'b10100, 64'hfffffffffffffff9, 64'd2, 64'hfffffffffffffffd, 66, "div64", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- XLEN-parametrised execute unit. Covers the RV32I/RV64I integer ALU operations plus the M-extension multiply/divide operations.
- Base ops complete in a fixed single cycle. MUL/DIV ops run on an iterative radix-2 datapath of XLEN iterations.
- Sits in the EX stage behind a valid/ready handshake, so the pipeline stalls while a multi-cycle op is in flight.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  unit can accept an op this cycle.
- operand1  input  XLEN  rs1 value.
- operand2  input  XLEN  rs2 value or immediate.
- operation  input  5  {m_ext, imm7[5], funct3}; m_ext=1 selects the M ops.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result.
- result  output  XLEN  computed value.
- busy  output  1  high in CALC or FIX.

Behaviour:
- Reset is asynchronous and active-low.
  - On assertion: state=IDLE, out_valid=0, result=0, busy=0. in_ready=1 once rst_n deasserts.
  - Reset mid-operation aborts the op; no result is produced.
- in_ready = (state==IDLE). An op is accepted on an edge where in_valid && in_ready. operand1, operand2 and operation are captured on that edge.
- Base ops (m_ext=0):
  - Encoding: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
  - Shifts use operand2[SHW-1:0].
  - SLT/SLTU return 1 or 0, zero-extended.
  - Any other base encoding returns 0.
  - Path is IDLE->DONE; out_valid is high in the cycle after acceptance (latency 1).
- M ops (m_ext=1, imm7[5]=0): funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU. Encodings with imm7[5]=1 return 0 with latency 1.
- M-op path is IDLE->CALC->FIX->DONE.
  - Acceptance edge: magnitudes and result-sign flags are latched. MULHSU treats operand1 as signed and operand2 as unsigned.
  - CALC: exactly XLEN cycles, driven by an iteration counter 0..XLEN-1.
    - Multiply: shift-add into a 2*XLEN accumulator.
    - Divide: restoring shift-subtract.
  - FIX: one cycle; conditional two's-complement negation, then selection of the low or high half, or the quotient or remainder.
  - out_valid rises XLEN+2 cycles after the acceptance edge.
- Special cases resolve on the acceptance edge and go directly to DONE (latency 1):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = operand1.
  - Signed overflow (operand1 = most-negative value, operand2 = -1): DIV = operand1, REM = 0.
- DONE:
  - result and out_valid are held stable until out_ready.
  - On the edge where out_valid && out_ready: state becomes IDLE and out_valid falls.
  - A new op is never accepted in the same cycle a result is consumed; back-to-back base ops therefore sustain one op every 2 cycles.
- in_valid is ignored in CALC, FIX and DONE. Operand changes after acceptance have no effect.
- result is 0 outside DONE.

Decomposition:
- Package alu_pkg:
  - op encoding constants (OP_ADD..OP_REMU), typedef op_t as logic[4:0];
  - state enum state_t {IDLE, CALC, FIX, DONE}.
- Sub-module alu_core: purely combinational base-op ALU parametrised on XLEN. Instantiated once; its output is registered into result on the acceptance edge for base ops.

Test Plan:
- XLEN=32, ADD 0x7FFFFFFF+1 -> result 0x80000000, out_valid exactly 1 cycle after acceptance. SRA 0x80000000 by 31 -> 0xFFFFFFFF.
- MULH -3 x 5 -> 0xFFFFFFFF; MUL -> 0xFFFFFFF1; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. Each with out_valid exactly 34 cycles after acceptance and busy high for 33 cycles.
- DIV -7/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF. DIVU 7/0 -> 0xFFFFFFFF in 1 cycle. DIV 0x80000000/-1 -> 0x80000000 and REM -> 0 in 1 cycle.
- Hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0. Then out_ready=1 -> in_ready=1 next cycle. in_valid pulses during CALC are ignored.
- Assert rst_n=0 at CALC iteration 10 -> out_valid, busy and result go to 0 immediately. After release, ADD 2+3 -> 5 with latency 1.
- XLEN=64: MULHU 2^63 x 4 -> 2, latency 66. Undefined op 11000 -> 0 with latency 1.
